// File: rtl/bot_irq_responder.sv
// bot_irq_responder: responder end of the bot-update request/acknowledge
// handshake in the clk50 domain. A synchronised request flag raises a level
// interrupt to the CPU. The CPU acknowledge then produces an IO_INT_ACK pulse
// that clears the flag, followed by a one-cycle drain before the next request.
// Optional watchdog: define BOT_IRQ_TIMEOUT_EN to force the acknowledge when
// the CPU stalls in REQ for TIMEOUT_CYCLES cycles.
module bot_irq_responder #(
  parameter int unsigned ACK_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk50,
  input  logic             reset_n,
  input  logic             IO_BotUpdt_Sync,
  input  logic             cpu_int_ack,
  input  logic             irq_enable,
  input  logic             timeout_clr,
  output logic             interrupt,
  output logic             IO_INT_ACK,
  output logic             busy,
  output logic [CNT_W-1:0] upd_count,
  output logic             timeout_flag
);

  localparam int unsigned ACKW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [ACKW-1:0] ACK_LOAD = ACKW'(ACK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK,
    S_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ACKW-1:0]  r_ack_cnt;
  logic             w_count;
  logic             r_interrupt;
  logic             r_io_ack;
  logic             r_busy;
  logic [CNT_W-1:0] r_upd_count;
  logic             w_timeout;

`ifdef BOT_IRQ_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_to_flag;

  // Watchdog fires on the TIMEOUT_CYCLES-th clock edge spent in REQ.
  assign w_timeout = (r_state == S_REQ) && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Watchdog cycle counter: cleared on entry to REQ, advances while in REQ.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if ((r_state != S_REQ) && (w_next == S_REQ)) begin
      r_to_cnt <= '0;
    end else if (r_state == S_REQ) begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  // Sticky timeout flag; a new timeout takes priority over a clear request.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_to_flag <= 1'b0;
    end else if (w_timeout && !cpu_int_ack) begin
      r_to_flag <= 1'b1;
    end else if (timeout_clr) begin
      r_to_flag <= 1'b0;
    end
  end

  assign timeout_flag = r_to_flag;
`else
  logic w_unused_timeout_clr;

  assign w_unused_timeout_clr = timeout_clr;
  assign w_timeout            = 1'b0;
  assign timeout_flag         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and the "count this service" strobe.
  always_comb begin
    w_next  = r_state;
    w_count = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (IO_BotUpdt_Sync && irq_enable) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (cpu_int_ack) begin
          w_next  = S_ACK;
          w_count = 1'b1;
        end else if (w_timeout) begin
          w_next  = S_ACK;
          w_count = 1'b1;
        end else if (!irq_enable) begin
          // Request withdrawn: still pulse the ack so the flag is discarded.
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        if (r_ack_cnt == '0) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Ack pulse-width down-counter, loaded on entry to ACK.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_cnt <= '0;
    end else if ((r_state != S_ACK) && (w_next == S_ACK)) begin
      r_ack_cnt <= ACK_LOAD;
    end else if ((r_state == S_ACK) && (r_ack_cnt != '0)) begin
      r_ack_cnt <= r_ack_cnt - 1'b1;
    end
  end

  // Registered Moore outputs, decoded from the state being entered.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_interrupt <= 1'b0;
      r_io_ack    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_interrupt <= (w_next == S_REQ);
      r_io_ack    <= (w_next == S_ACK);
      r_busy      <= (w_next != S_IDLE);
    end
  end

  // Serviced-update counter, wraps silently.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_upd_count <= '0;
    end else if (w_count) begin
      r_upd_count <= r_upd_count + 1'b1;
    end
  end

  assign interrupt  = r_interrupt;
  assign IO_INT_ACK = r_io_ack;
  assign busy       = r_busy;
  assign upd_count  = r_upd_count;

endmodule

// File: tb/tb_bot_irq_responder.sv
// Self-checking bench for bot_irq_responder. Each service round is described
// at transaction level (cycles in REQ, how it ends) and the expected output
// timeline and update count are derived from that description.
module tb_bot_irq_responder;

  localparam int unsigned ACK_C = 2;
  localparam int unsigned TO_C  = 20;
  localparam int unsigned CW    = 8;

  logic          clk50;
  logic          reset_n;
  logic          IO_BotUpdt_Sync;
  logic          cpu_int_ack;
  logic          irq_enable;
  logic          timeout_clr;
  logic          interrupt;
  logic          IO_INT_ACK;
  logic          busy;
  logic [CW-1:0] upd_count;
  logic          timeout_flag;

  int unsigned n_cmp   = 0;
  int unsigned n_bad   = 0;
  int unsigned exp_cnt = 0;
  bit          exp_to  = 1'b0;

  bot_irq_responder #(
    .ACK_CYCLES    (ACK_C),
    .TIMEOUT_CYCLES(TO_C),
    .CNT_W         (CW)
  ) dut (
    .clk50          (clk50),
    .reset_n        (reset_n),
    .IO_BotUpdt_Sync(IO_BotUpdt_Sync),
    .cpu_int_ack    (cpu_int_ack),
    .irq_enable     (irq_enable),
    .timeout_clr    (timeout_clr),
    .interrupt      (interrupt),
    .IO_INT_ACK     (IO_INT_ACK),
    .busy           (busy),
    .upd_count      (upd_count),
    .timeout_flag   (timeout_flag)
  );

  initial begin
    clk50 = 1'b0;
    forever #5 clk50 = ~clk50;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input bit e_int, input bit e_ack, input bit e_busy);
    chk({tag, ".interrupt"}, 32'(interrupt), 32'(e_int));
    chk({tag, ".io_int_ack"}, 32'(IO_INT_ACK), 32'(e_ack));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".upd_count"}, 32'(upd_count), exp_cnt % (32'd1 << CW));
    chk({tag, ".timeout_flag"}, 32'(timeout_flag), 32'(exp_to));
  endtask

  // One service round. mode: 0 = CPU ack, 1 = irq_enable withdrawn,
  // 2 = ack and withdrawal on the same edge. 'already' means the request
  // flag is already up and REQ is entered on the next edge.
  task automatic round(input int unsigned dly, input int unsigned mode,
                       input bit already, input bit fall, input bit reflag);
    if (!already) begin
      @(negedge clk50);
      chk_outs("idle", 1'b0, 1'b0, 1'b0);
      IO_BotUpdt_Sync = 1'b1;
      irq_enable      = 1'b1;
    end
    for (int unsigned i = 0; i < dly; i++) begin
      @(negedge clk50);
      chk_outs("req", 1'b1, 1'b0, 1'b1);
      if (fall && (i == 0)) IO_BotUpdt_Sync = 1'b0;
      if (i == dly - 1) begin
        cpu_int_ack = (mode != 1);
        irq_enable  = (mode == 0);
      end
    end
    if (mode != 1) exp_cnt++;
    for (int unsigned k = 0; k < ACK_C; k++) begin
      @(negedge clk50);
      chk_outs("ack", 1'b0, 1'b1, 1'b1);
      cpu_int_ack     = 1'b0;
      irq_enable      = 1'b1;
      IO_BotUpdt_Sync = 1'b0;
    end
    @(negedge clk50);
    chk_outs("drain", 1'b0, 1'b0, 1'b1);
    if (reflag) IO_BotUpdt_Sync = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk50);
    reset_n = 1'b0;
    exp_cnt = 0;
    exp_to  = 1'b0;
    repeat (2) @(negedge clk50);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b0;
    IO_BotUpdt_Sync = 1'b0;
    cpu_int_ack     = 1'b0;
    irq_enable      = 1'b1;
    timeout_clr     = 1'b0;
    repeat (3) @(negedge clk50);
    reset_n = 1'b1;
    @(negedge clk50);
    chk_outs("reset", 1'b0, 1'b0, 1'b0);

    // Interrupt for 5 cycles, ack pulse of ACK_C cycles, drain, idle.
    round(5, 0, 1'b0, 1'b0, 1'b0);
    round(3, 1, 1'b0, 1'b0, 1'b0);
    round(2, 2, 1'b0, 1'b0, 1'b0);
    round(1, 0, 1'b0, 1'b1, 1'b0);

    // Acknowledge outside REQ is ignored.
    @(negedge clk50);
    cpu_int_ack = 1'b1;
    @(negedge clk50);
    cpu_int_ack = 1'b0;
    chk_outs("stray_ack", 1'b0, 1'b0, 1'b0);
    // Request with irq_enable low is not serviced.
    IO_BotUpdt_Sync = 1'b1;
    irq_enable      = 1'b0;
    repeat (2) @(negedge clk50);
    chk_outs("disabled", 1'b0, 1'b0, 1'b0);
    IO_BotUpdt_Sync = 1'b0;
    irq_enable      = 1'b1;

    // Randomised rounds.
    for (int unsigned r = 0; r < 40; r++) begin
      round($urandom_range(6, 1), $urandom_range(2, 0), 1'b0,
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    // Reset during the ack pulse; flag still high afterwards.
    @(negedge clk50);
    IO_BotUpdt_Sync = 1'b1;
    irq_enable      = 1'b1;
    @(negedge clk50);
    chk_outs("pre_rst_req", 1'b1, 1'b0, 1'b1);
    cpu_int_ack = 1'b1;
    @(negedge clk50);
    cpu_int_ack = 1'b0;
    exp_cnt++;
    chk_outs("pre_rst_ack", 1'b0, 1'b1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    exp_cnt = 0;
    exp_to  = 1'b0;
    chk_outs("async_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk50);
    reset_n = 1'b1;
    round(2, 0, 1'b1, 1'b0, 1'b0);

    // 300 back-to-back rounds; count wraps modulo 256.
    do_reset();
    for (int unsigned r = 0; r < 300; r++) begin
      round($urandom_range(3, 1), 0, 1'b0, 1'b0, 1'b0);
    end
    chk("count_300", 32'(upd_count), 32'd44);

`ifdef BOT_IRQ_TIMEOUT_EN
    // Watchdog: no CPU ack, forced acknowledge after TO_C cycles in REQ.
    @(negedge clk50);
    chk_outs("to_idle", 1'b0, 1'b0, 1'b0);
    IO_BotUpdt_Sync = 1'b1;
    for (int unsigned i = 0; i < TO_C; i++) begin
      @(negedge clk50);
      chk_outs("to_req", 1'b1, 1'b0, 1'b1);
    end
    exp_cnt++;
    exp_to = 1'b1;
    for (int unsigned k = 0; k < ACK_C; k++) begin
      @(negedge clk50);
      chk_outs("to_ack", 1'b0, 1'b1, 1'b1);
      IO_BotUpdt_Sync = 1'b0;
    end
    @(negedge clk50);
    chk_outs("to_drain", 1'b0, 1'b0, 1'b1);
    timeout_clr = 1'b1;
    @(negedge clk50);
    timeout_clr = 1'b0;
    exp_to      = 1'b0;
    chk_outs("to_clr", 1'b0, 1'b0, 1'b0);
`else
    // Without the watchdog, REQ waits indefinitely.
    @(negedge clk50);
    IO_BotUpdt_Sync = 1'b1;
    timeout_clr     = 1'b1;
    repeat (TO_C + 5) @(negedge clk50);
    chk_outs("no_watchdog", 1'b1, 1'b0, 1'b1);
    timeout_clr = 1'b0;
    cpu_int_ack = 1'b1;
    @(negedge clk50);
    cpu_int_ack     = 1'b0;
    IO_BotUpdt_Sync = 1'b0;
    exp_cnt++;
    chk_outs("late_ack", 1'b0, 1'b1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
